// File: rtl/lsu_seq_ctrl.sv
// Multi-cycle load/store sequencer: reads base/data registers, forms the word
// address, runs the data-memory request/ready handshake and writes back loads.
//
// state  | meaning
// IDLE   | waiting for start; all outputs low
// READ   | register-file read addresses driven, base/store data captured
// ADDR   | address formed; odd address aborts
// REQ    | mem_req held until mem_ready or timeout
// WB     | one-cycle register-file write of load data
// DONE   | one-cycle done pulse
// ERR    | one-cycle done+err pulse (misaligned or timeout)
module lsu_seq_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] instr,
  input  logic        is_store,
  output logic [3:0]  rf_raddr_p,
  output logic [3:0]  rf_raddr_d,
  input  logic [15:0] rf_rdata_p,
  input  logic [15:0] rf_rdata_d,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_ADDR, S_REQ, S_WB, S_DONE, S_ERR
  } state_t;

  state_t      state, state_nx;
  logic [15:0] instr_q;
  logic        store_q;
  logic [15:0] base_q;
  logic [15:0] sdata_q;
  logic [15:0] addr_q;
  logic [15:0] rdata_q;
  logic [7:0]  cnt_q;

  logic [15:0] off;
  logic [15:0] addr_sum;
  logic        req_last;

  // Offset is in words; shift to bytes and let the sum wrap modulo 2^16.
  assign off      = {{7{instr_q[7]}}, instr_q[7:0], 1'b0};
  assign addr_sum = base_q + off;
  assign req_last = (cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q <= '0;
      store_q <= 1'b0;
      base_q  <= '0;
      sdata_q <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            instr_q <= instr;
            store_q <= is_store;
          end
        end
        S_READ: begin
          base_q  <= rf_rdata_p;
          sdata_q <= rf_rdata_d;
        end
        S_ADDR: begin
          addr_q <= addr_sum;
          cnt_q  <= '0;
        end
        S_REQ: begin
          if (mem_ready) begin
            if (!store_q) rdata_q <= mem_rdata;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_READ;
      S_READ: state_nx = S_ADDR;
      S_ADDR: state_nx = addr_sum[0] ? S_ERR : S_REQ;
      S_REQ: begin
        // A ready arriving on the last allowed cycle still completes.
        if (mem_ready)     state_nx = store_q ? S_DONE : S_WB;
        else if (req_last) state_nx = S_ERR;
      end
      S_WB:    state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    rf_raddr_p = busy ? {2'b10, instr_q[9:8]} : 4'd0;
    rf_raddr_d = busy ? {2'b11, instr_q[11:10]} : 4'd0;
    mem_req    = (state == S_REQ);
    mem_we     = mem_req && store_q;
    mem_addr   = mem_req ? addr_q : 16'd0;
    mem_wdata  = mem_we ? sdata_q : 16'd0;
    rf_we      = (state == S_WB);
    rf_waddr   = rf_we ? {2'b11, instr_q[11:10]} : 4'd0;
    rf_wdata   = rf_we ? rdata_q : 16'd0;
    done       = (state == S_DONE) || (state == S_ERR);
    err        = (state == S_ERR);
  end

endmodule

// File: tb/tb_lsu_seq_ctrl.sv
// Scoreboard bench for lsu_seq_ctrl: driver pushes expected outcomes computed
// from the instruction semantics, a monitor pops and compares on each done.
module tb_lsu_seq_ctrl;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n, start, is_store, mem_ready;
  logic [15:0] instr, mem_rdata, rf_rdata_p, rf_rdata_d;
  logic [3:0]  rf_raddr_p, rf_raddr_d, rf_waddr;
  logic        mem_req, mem_we, rf_we, busy, done, err;
  logic [15:0] mem_addr, mem_wdata, rf_wdata;

  logic [15:0] rf [16];
  assign rf_rdata_p = rf[rf_raddr_p];
  assign rf_rdata_d = rf[rf_raddr_d];

  lsu_seq_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .is_store(is_store),
    .rf_raddr_p(rf_raddr_p), .rf_raddr_d(rf_raddr_d),
    .rf_rdata_p(rf_rdata_p), .rf_rdata_d(rf_rdata_d),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic        err;
    int          lat;
    int          reqs;
    int          rfw;
    logic [3:0]  waddr;
    logic [15:0] rfdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cur_wait = 0;
  logic [15:0] cur_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Memory responder: ready after cur_wait not-ready request cycles.
  initial begin
    int req_n;
    req_n = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!mem_req) begin
        req_n = 0;
        mem_ready = 1'b0;
      end else begin
        mem_ready = (req_n == cur_wait);
        req_n++;
      end
      mem_rdata = mem_ready ? cur_rdata : 16'($urandom);
    end
  end

  // Monitor
  initial begin
    int tick, t0, req_cnt, rf_cnt;
    bit active, got_acc;
    logic [15:0] acc_addr, acc_wdata, rf_wd;
    logic acc_we;
    logic [3:0] rf_wa;
    exp_t e;
    tick = 0; t0 = 0; req_cnt = 0; rf_cnt = 0; active = 0; got_acc = 0;
    acc_addr = '0; acc_wdata = '0; rf_wd = '0; acc_we = 0; rf_wa = '0;
    forever begin
      @(negedge clk);
      #1;
      tick++;
      if (!rst_n) begin
        active = 0;
      end else begin
        if (start && !busy) begin
          active = 1; t0 = tick; req_cnt = 0; rf_cnt = 0; got_acc = 0;
        end
        if (mem_req) req_cnt++;
        if (mem_req && mem_ready) begin
          got_acc = 1; acc_addr = mem_addr; acc_we = mem_we; acc_wdata = mem_wdata;
        end
        if (rf_we) begin
          rf_cnt++; rf_wa = rf_waddr; rf_wd = rf_wdata;
        end
        if (err && !done) begin
          n_cmp++; n_bad++;
          $display("FAIL err_without_done at %0t", $time);
        end
        if (done) begin
          if (!active || exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_done: active=%0d queued=%0d at %0t", active, exp_q.size(), $time);
          end else begin
            e = exp_q.pop_front();
            chk("err", 32'(err), 32'(e.err));
            chk("latency", 32'(tick - t0), 32'(e.lat));
            chk("req_cycles", 32'(req_cnt), 32'(e.reqs));
            chk("accepted", 32'(got_acc), 32'(!e.err));
            if (got_acc && !e.err) begin
              chk("mem_addr", 32'(acc_addr), 32'(e.addr));
              chk("mem_we", 32'(acc_we), 32'(e.we));
              chk("mem_wdata", 32'(acc_wdata), 32'(e.wdata));
            end
            chk("rf_we_count", 32'(rf_cnt), 32'(e.rfw));
            if (rf_cnt == 1 && e.rfw == 1) begin
              chk("rf_waddr", 32'(rf_wa), 32'(e.waddr));
              chk("rf_wdata", 32'(rf_wd), 32'(e.rfdata));
            end
          end
          active = 0;
        end
      end
    end
  end

  task automatic run_txn(input logic [15:0] ins, input logic st, input logic [15:0] base,
                         input logic [15:0] data, input int wt, input logic [15:0] rd);
    exp_t e;
    int a;
    logic [7:0] o8;
    bit seen;
    o8 = ins[7:0];
    a = int'(base) + 2 * int'($signed(o8));
    e.addr  = a[15:0];
    e.we    = st;
    e.wdata = st ? data : 16'd0;
    e.waddr = {2'b11, ins[11:10]};
    e.rfdata = rd;
    if (e.addr[0]) begin
      e.err = 1; e.lat = 3; e.reqs = 0; e.rfw = 0;
    end else if (wt >= TO) begin
      e.err = 1; e.lat = 3 + TO; e.reqs = TO; e.rfw = 0;
    end else begin
      e.err = 0; e.reqs = wt + 1; e.lat = (st ? 4 : 5) + wt; e.rfw = st ? 0 : 1;
    end
    @(negedge clk);
    rf[{2'b10, ins[9:8]}] = base;
    rf[{2'b11, ins[11:10]}] = data;
    cur_wait = wt;
    cur_rdata = rd;
    instr = ins;
    is_store = st;
    start = 1'b1;
    exp_q.push_back(e);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      start = busy && ($urandom_range(0, 3) == 0);
      if (start) begin
        instr = 16'($urandom);
        is_store = 1'($urandom);
      end
      if (done) seen = 1;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: no done within 60 cycles for instr 0x%0h", ins);
    end
  endtask

  initial begin
    logic [15:0] b;
    int w;
    for (int i = 0; i < 16; i++) rf[i] = '0;
    rst_n = 1'b0; start = 1'b0; instr = '0; is_store = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_raddr_p", 32'(rf_raddr_p), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rf_we", 32'(rf_we), 0);
    rst_n = 1'b1;

    run_txn(16'h8505, 1'b0, 16'h1000, 16'h0000, 0, 16'hBEEF);
    run_txn(16'h80FE, 1'b0, 16'h0002, 16'h1234, 0, 16'hCAFE);
    run_txn(16'h8A10, 1'b1, 16'h2000, 16'h5A5A, 3, 16'h0000);
    run_txn(16'h8500, 1'b0, 16'h1001, 16'h0000, 0, 16'h1111);
    run_txn(16'h8505, 1'b0, 16'h1000, 16'h0000, TO + 5, 16'h2222);
    run_txn(16'h8505, 1'b0, 16'h1000, 16'h0000, TO - 1, 16'h3333);
    run_txn(16'h8A10, 1'b1, 16'h2000, 16'h5A5A, TO, 16'h0000);

    // Reset in the middle of REQ: request must drop with no completion.
    @(negedge clk);
    rf[9] = 16'h4000;
    cur_wait = 30;
    instr = 16'h8505; is_store = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("pre_reset_req", 32'(mem_req), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_req", 32'(mem_req), 0);
    chk("post_reset_busy", 32'(busy), 0);
    chk("post_reset_done", 32'(done), 0);
    chk("post_reset_rf_we", 32'(rf_we), 0);
    run_txn(16'h8505, 1'b0, 16'h1000, 16'h0000, 1, 16'hABCD);

    for (int n = 0; n < 40; n++) begin
      b = 16'($urandom);
      if ($urandom_range(0, 5) != 0) b[0] = 1'b0;
      case ($urandom_range(0, 7))
        0:       w = TO - 1;
        1:       w = TO;
        default: w = $urandom_range(0, 4);
      endcase
      run_txn(16'($urandom), 1'($urandom), b, 16'($urandom), w, 16'($urandom));
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
